// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, op indices, sequencer states and the wide-op helper
package alu_pkg;
  localparam int BITS = 32;
  localparam int SIG_COUNT = 13;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_NEG = 4'd11;
  localparam logic [3:0] OP_NOT = 4'd12;
  typedef enum logic [1:0] {IDLE, EXEC, SEND_LO, SEND_HI} state_t;
  // MUL and DIV fill both halves of Z, so they return two words
  function automatic logic is_wide(input logic [3:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/op_onehot_dec.sv
// op_onehot_dec: 4-bit op index to one-hot ALU control plus legality flag
//   op     in  4  encoded op index
//   onehot out N  1<<op when legal, else all-zero
//   legal  out 1  op < N
module op_onehot_dec #(
  parameter int N = alu_pkg::SIG_COUNT
) (
  input  logic [3:0]   op,
  output logic [N-1:0] onehot,
  output logic         legal
);
  assign legal = int'(op) < N;
  assign onehot = legal ? N'(1) << op : '0;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives one ALU op, captures its 64-bit result and streams it out as 32-bit words
//   clk, clr (async active-low reset)
//   req_valid/req_ready/req_op/req_x/req_y  request side
//   alu_ctrl/alu_x/alu_y/alu_result         ALU interface (result is combinational)
//   out_valid/out_ready/out_data/out_hi/out_last  result word stream
//   err_illegal                              one-cycle pulse for an accepted out-of-range op
module alu_op_sequencer #(
  parameter int BITS = alu_pkg::BITS,
  parameter int SIG_COUNT = alu_pkg::SIG_COUNT
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [BITS-1:0]      req_x,
  input  logic [BITS-1:0]      req_y,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [2*BITS-1:0]    alu_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      out_data,
  output logic                 out_hi,
  output logic                 out_last,
  output logic                 err_illegal
);
  import alu_pkg::*;
  state_t state;
  logic [SIG_COUNT-1:0] onehot;
  logic legal;
  logic wide;
  logic xfer;
  logic [2*BITS-1:0] z;
  op_onehot_dec #(.N(SIG_COUNT)) u_dec (
    .op(req_op),
    .onehot(onehot),
    .legal(legal)
  );
  assign req_ready = state == IDLE;
  assign xfer = out_valid && out_ready;
  // alu_ctrl is loaded on acceptance so it is live for exactly the EXEC cycle;
  // the low word is loaded straight from alu_result so it is valid on entry to SEND_LO
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state <= IDLE;
      alu_ctrl <= '0;
      alu_x <= '0;
      alu_y <= '0;
      wide <= 1'b0;
      z <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_hi <= 1'b0;
      out_last <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          alu_x <= req_x;
          alu_y <= req_y;
          wide <= is_wide(req_op);
          alu_ctrl <= onehot;
          err_illegal <= !legal;
          if (legal) state <= EXEC;
        end
        EXEC: begin
          alu_ctrl <= '0;
          z <= alu_result;
          out_data <= alu_result[BITS-1:0];
          out_hi <= 1'b0;
          out_last <= !wide;
          out_valid <= 1'b1;
          state <= SEND_LO;
        end
        SEND_LO: if (xfer) begin
          if (wide) begin
            out_data <= z[2*BITS-1:BITS];
            out_hi <= 1'b1;
            out_last <= 1'b1;
            state <= SEND_HI;
          end else begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            state <= IDLE;
          end
        end
        SEND_HI: if (xfer) begin
          out_valid <= 1'b0;
          out_hi <= 1'b0;
          out_last <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: vector table and corner-case sequences with a word scoreboard
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] req_op = '0;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic [12:0] alu_ctrl;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [63:0] alu_result;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_data;
  logic out_hi;
  logic out_last;
  logic err_illegal;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] data;
    logic hi;
    logic last;
  } word_t;
  word_t sb[$];

  typedef struct {
    logic [3:0] op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] lo;
    logic [31:0] hi;
    logic wide;
  } vec_t;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk),
    .clr(clr),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_x(req_x),
    .req_y(req_y),
    .alu_ctrl(alu_ctrl),
    .alu_x(alu_x),
    .alu_y(alu_y),
    .alu_result(alu_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_hi(out_hi),
    .out_last(out_last),
    .err_illegal(err_illegal)
  );

  // combinational ALU stand-in driven by the sequencer's control outputs
  logic signed [31:0] sx, sy;
  logic signed [63:0] prod;
  assign sx = alu_x;
  assign sy = alu_y;
  assign prod = 64'(sx) * 64'(sy);
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      13'h0001: alu_result = {32'h0, alu_x + alu_y};
      13'h0002: alu_result = {32'h0, alu_x - alu_y};
      13'h0004: alu_result = prod;
      13'h0008: alu_result = (sy == 0) ? 64'h0 : {32'(sx % sy), 32'(sx / sy)};
      13'h0010: alu_result = {32'h0, alu_x & alu_y};
      13'h0020: alu_result = {32'h0, alu_x | alu_y};
      13'h0040: alu_result = {32'h0, alu_x >> alu_y[4:0]};
      13'h0080: alu_result = {32'h0, 32'(sx >>> alu_y[4:0])};
      13'h0100: alu_result = {32'h0, alu_x << alu_y[4:0]};
      13'h0200: alu_result = {32'h0, (alu_x >> alu_y[4:0]) | (alu_x << (6'd32 - {1'b0, alu_y[4:0]}))};
      13'h0400: alu_result = {32'h0, (alu_x << alu_y[4:0]) | (alu_x >> (6'd32 - {1'b0, alu_y[4:0]}))};
      13'h0800: alu_result = {32'h0, -alu_x};
      13'h1000: alu_result = {32'h0, ~alu_x};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // a word is taken at the posedge following a negedge that sees valid && ready
  always @(negedge clk)
    if (clr && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_word: got data=%h hi=%0d last=%0d expected no word", out_data, out_hi, out_last);
      end else begin
        word_t w;
        w = sb.pop_front();
        check("word{data,hi,last}", {out_data, out_hi, out_last}, {w.data, w.hi, w.last});
      end
    end

  task automatic push_exp(input logic [31:0] lo, input logic [31:0] hi, input logic wide);
    sb.push_back('{lo, 1'b0, !wide});
    if (wide) sb.push_back('{hi, 1'b1, 1'b1});
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    for (int i = 0; i < 20 && !req_ready; i++) tick;
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_op = op;
    req_x = x;
    req_y = y;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int cnt;
    vt[0] = '{4'd0, 32'd15, 32'd5, 32'h00000014, 32'h0, 1'b0};
    vt[1] = '{4'd1, 32'd15, 32'd5, 32'h0000000A, 32'h0, 1'b0};
    vt[2] = '{4'd2, -32'sd15, 32'd5, 32'hFFFFFFB5, 32'hFFFFFFFF, 1'b1};
    vt[3] = '{4'd3, 32'd15, -32'sd5, 32'hFFFFFFFD, 32'h00000000, 1'b1};
    vt[4] = '{4'd4, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0, 1'b0};
    vt[5] = '{4'd5, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'h0, 1'b0};
    vt[6] = '{4'd8, 32'd1, 32'd4, 32'h00000010, 32'h0, 1'b0};
    vt[7] = '{4'd12, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
    vt[8] = '{4'd2, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1};
    vt[9] = '{4'd11, 32'd5, 32'd0, 32'hFFFFFFFB, 32'h0, 1'b0};
    vt[10] = '{4'd0, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'h0, 1'b0};
    tick;
    tick;
    check("rst_req_ready", req_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err_illegal, 0);
    check("rst_alu_x", alu_x, 0);
    clr = 1'b1;
    tick;
    // ADD latency: EXEC after acceptance, word present the following cycle
    do_req(4'd0, 32'd15, 32'd5);
    push_exp(32'h14, 32'h0, 1'b0);
    check("add_exec_ctrl", alu_ctrl, 13'h0001);
    check("add_exec_ready", req_ready, 0);
    check("add_exec_valid", out_valid, 0);
    tick;
    check("add_word_valid", out_valid, 1);
    check("add_word", {out_data, out_hi, out_last}, {32'h14, 1'b0, 1'b1});
    tick;
    check("add_done_valid", out_valid, 0);
    check("add_done_ready", req_ready, 1);
    drain;
    foreach (vt[i]) begin
      do_req(vt[i].op, vt[i].x, vt[i].y);
      push_exp(vt[i].lo, vt[i].hi, vt[i].wide);
      drain;
    end
    // DIV: control bit 3 present for exactly one cycle
    do_req(4'd3, 32'd15, -32'sd5);
    push_exp(32'hFFFFFFFD, 32'h0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (alu_ctrl == 13'h0008) cnt++;
      tick;
    end
    check("div_ctrl_cycles", cnt, 1);
    drain;
    // backpressure with an ignored request while busy
    out_ready = 1'b0;
    do_req(4'd2, 32'd15, 32'd5);
    push_exp(32'h4B, 32'h0, 1'b1);
    tick;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_op = 4'd0;
      check("bp_valid", out_valid, 1);
      check("bp_word", {out_data, out_hi, out_last}, {32'h4B, 1'b0, 1'b0});
      check("bp_req_ready", req_ready, 0);
      tick;
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    drain;
    tick;
    tick;
    check("bp_idle_ready", req_ready, 1);
    check("bp_no_extra", out_valid, 0);
    // illegal op
    do_req(4'd13, 32'd1, 32'd1);
    check("ill_err", err_illegal, 1);
    check("ill_ctrl", alu_ctrl, 0);
    check("ill_ready", req_ready, 1);
    check("ill_valid", out_valid, 0);
    do_req(4'd0, 32'd1, 32'd2);
    push_exp(32'h3, 32'h0, 1'b0);
    check("ill_err_pulse", err_illegal, 0);
    check("ill_next_ctrl", alu_ctrl, 13'h0001);
    drain;
    // reset while the high word is pending
    do_req(4'd2, -32'sd15, 32'd5);
    sb.push_back('{32'hFFFFFFB5, 1'b0, 1'b0});
    tick;
    tick;
    out_ready = 1'b0;
    check("rm_hi_word", {out_valid, out_data, out_hi, out_last}, {1'b1, 32'hFFFFFFFF, 1'b1, 1'b1});
    #2;
    clr = 1'b0;
    #1;
    check("rm_async_outs", {out_valid, out_data, out_hi, out_last}, 0);
    check("rm_async_ctrl", {alu_ctrl, err_illegal}, 0);
    check("rm_async_x", alu_x, 0);
    check("rm_async_ready", req_ready, 1);
    tick;
    clr = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    check("rm_after_valid", out_valid, 0);
    check("rm_after_ready", req_ready, 1);
    do_req(4'd0, 32'd2, 32'd3);
    push_exp(32'h5, 32'h0, 1'b0);
    drain;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
